// File: rtl/ph_pkg.sv
// rtl/ph_pkg.sv - shared phase-bus constants, decoder state encoding and error codes
package ph_pkg;

    localparam logic [3:0] PH_IDLE = 4'b0000;
    localparam logic [3:0] PH0     = 4'b0001;
    localparam logic [3:0] PH1     = 4'b0010;
    localparam logic [3:0] PH2     = 4'b0100;
    localparam logic [3:0] PH3     = 4'b1000;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_START  = 2'd1;
    localparam logic [1:0] ERR_SEQ    = 2'd2;
    localparam logic [1:0] ERR_ONEHOT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S3   = 3'd4,
        ST_ERR  = 3'd5
    } ph_state_t;

    function automatic ph_state_t phase_state(input logic [1:0] idx);
        case (idx)
            2'd0:    return ST_S0;
            2'd1:    return ST_S1;
            2'd2:    return ST_S2;
            default: return ST_S3;
        endcase
    endfunction

    function automatic logic [1:0] state_phase(input ph_state_t st);
        case (st)
            ST_S1:   return 2'd1;
            ST_S2:   return 2'd2;
            ST_S3:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ph_onehot_chk.sv
// rtl/ph_onehot_chk.sv - classifies a phase vector as zero / one-hot and gives its bit index
module ph_onehot_chk
    import ph_pkg::*;
(
    input  logic [3:0] ph,
    output logic       is_zero,
    output logic       is_onehot,
    output logic [1:0] idx
);

    always_comb begin
        is_zero   = (ph == PH_IDLE);
        is_onehot = (ph != PH_IDLE) && ((ph & (ph - 4'd1)) == 4'd0);
        case (ph)
            PH1:     idx = 2'd1;
            PH2:     idx = 2'd2;
            PH3:     idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/ph_decoder.sv
// rtl/ph_decoder.sv - phase-bus consumer: stage strobes, instruction count, illegal-sequence trap
module ph_decoder
    import ph_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [3:0]       ph,
    input  logic             clr_err,
    output logic             run,
    output logic             fetch_en,
    output logic             dec_en,
    output logic             exe_en,
    output logic             wb_en,
    output logic [CNT_W-1:0] icount,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             halt_req
);

    logic             w_is_zero;
    logic             w_is_onehot;
    logic [1:0]       w_idx;
    logic [1:0]       w_cur_idx;
    ph_state_t        w_next;
    logic [1:0]       w_code;

    ph_state_t        r_state;
    logic             r_run;
    logic             r_fetch;
    logic             r_dec;
    logic             r_exe;
    logic             r_wb;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_icount;

    ph_onehot_chk u_chk (
        .ph        (ph),
        .is_zero   (w_is_zero),
        .is_onehot (w_is_onehot),
        .idx       (w_idx)
    );

    assign w_cur_idx = state_phase(r_state);

    // Non-one-hot input is tested before any order check so it always wins as code 3.
    always_comb begin
        w_next = r_state;
        w_code = r_err_code;
        case (r_state)
            ST_IDLE: begin
                if (w_is_zero) begin
                    w_next = ST_IDLE;
                end else if (!w_is_onehot) begin
                    w_next = ST_ERR;
                    w_code = ERR_ONEHOT;
                end else if (w_idx == 2'd0) begin
                    w_next = ST_S0;
                end else begin
                    w_next = ST_ERR;
                    w_code = ERR_START;
                end
            end
            ST_S0, ST_S1, ST_S2, ST_S3: begin
                if (w_is_zero) begin
                    w_next = ST_IDLE;
                end else if (!w_is_onehot) begin
                    w_next = ST_ERR;
                    w_code = ERR_ONEHOT;
                end else if (w_idx == 2'(w_cur_idx + 2'd1)) begin
                    w_next = phase_state(w_idx);
                end else begin
                    w_next = ST_ERR;
                    w_code = ERR_SEQ;
                end
            end
            ST_ERR: begin
                if (clr_err && w_is_zero) begin
                    w_next = ST_IDLE;
                    w_code = ERR_NONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
                w_code = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= ST_IDLE;
            r_run      <= 1'b0;
            r_fetch    <= 1'b0;
            r_dec      <= 1'b0;
            r_exe      <= 1'b0;
            r_wb       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_next;
            r_run      <= (w_next == ST_S0) || (w_next == ST_S1) ||
                          (w_next == ST_S2) || (w_next == ST_S3);
            r_fetch    <= (w_next == ST_S0);
            r_dec      <= (w_next == ST_S1);
            r_exe      <= (w_next == ST_S2);
            r_wb       <= (w_next == ST_S3);
            r_err      <= (w_next == ST_ERR);
            r_err_code <= w_code;
        end
    end

    // S3 is only reachable from S2, so next-state S3 is exactly one completed instruction.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_icount <= '0;
        end else if ((w_next == ST_S3) && (r_icount != {CNT_W{1'b1}})) begin
            r_icount <= r_icount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign run      = r_run;
    assign fetch_en = r_fetch;
    assign dec_en   = r_dec;
    assign exe_en   = r_exe;
    assign wb_en    = r_wb;
    assign icount   = r_icount;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign halt_req = r_err;

endmodule

// File: tb/tb_ph_decoder.sv
// tb/tb_ph_decoder.sv - self-checking bench for ph_decoder (16-bit and 3-bit counter instances)
module tb_ph_decoder;

    logic        CLK;
    logic        RSTN;
    logic [3:0]  ph;
    logic        clr_err;

    logic        run_a, fetch_a, dec_a, exe_a, wb_a, err_a, halt_a;
    logic [1:0]  code_a;
    logic [15:0] icount_a;
    logic        run_b, fetch_b, dec_b, exe_b, wb_b, err_b, halt_b;
    logic [1:0]  code_b;
    logic [2:0]  icount_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: mode -1 idle, 0..3 last legal phase, 4 error
    int m_mode;
    int m_code;
    int m_ic16;
    int m_ic3;

    typedef struct {
        logic [3:0] ph;
        logic       clr;
        logic [3:0] str;
        logic       run;
        logic       err;
        logic [1:0] code;
        int         ic;
    } vec_t;

    vec_t tbl[$];

    ph_decoder #(.CNT_W(16)) dut_a (
        .CLK(CLK), .RSTN(RSTN), .ph(ph), .clr_err(clr_err),
        .run(run_a), .fetch_en(fetch_a), .dec_en(dec_a), .exe_en(exe_a), .wb_en(wb_a),
        .icount(icount_a), .err(err_a), .err_code(code_a), .halt_req(halt_a)
    );

    ph_decoder #(.CNT_W(3)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .ph(ph), .clr_err(clr_err),
        .run(run_b), .fetch_en(fetch_b), .dec_en(dec_b), .exe_en(exe_b), .wb_en(wb_b),
        .icount(icount_b), .err(err_b), .err_code(code_b), .halt_req(halt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // flags packed as {run, wb, exe, dec, fetch, err, halt, code[1:0]}
    function automatic logic [31:0] flags_a();
        return {23'd0, run_a, wb_a, exe_a, dec_a, fetch_a, err_a, halt_a, code_a};
    endfunction

    function automatic logic [31:0] flags_b();
        return {23'd0, run_b, wb_b, exe_b, dec_b, fetch_b, err_b, halt_b, code_b};
    endfunction

    function automatic logic [31:0] pack_exp(input logic r, input logic [3:0] s,
                                             input logic e, input logic [1:0] c);
        return {23'd0, r, s, e, e, c};
    endfunction

    task automatic model_reset();
        m_mode = -1;
        m_code = 0;
        m_ic16 = 0;
        m_ic3  = 0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic c);
        int ones;
        int idx;
        int want;
        ones = $countones(p);
        idx  = 0;
        for (int i = 0; i < 4; i++) if (p[i]) idx = i;
        if (m_mode == 4) begin
            if (c && p == 4'b0000) begin
                m_mode = -1;
                m_code = 0;
            end
        end else if (ones > 1) begin
            m_mode = 4;
            m_code = 3;
        end else if (ones == 0) begin
            m_mode = -1;
        end else begin
            want = (m_mode < 0) ? 0 : (m_mode + 1) % 4;
            if (idx == want) begin
                m_mode = idx;
                if (idx == 3) begin
                    if (m_ic16 < 65535) m_ic16++;
                    if (m_ic3 < 7) m_ic3++;
                end
            end else begin
                m_mode = 4;
                m_code = (m_mode < 0) ? 1 : 2;
                m_code = 0;
            end
        end
    endtask

    task automatic model_err_code(input int prev_mode);
        if (m_mode == 4 && m_code == 0) m_code = (prev_mode < 0) ? 1 : 2;
    endtask

    task automatic model_full(input logic [3:0] p, input logic c);
        int prev;
        prev = m_mode;
        model_step(p, c);
        model_err_code(prev);
    endtask

    function automatic logic [31:0] model_flags();
        logic [3:0] s;
        logic       r;
        s = 4'b0000;
        r = (m_mode >= 0 && m_mode <= 3);
        if (r) s[m_mode] = 1'b1;
        return pack_exp(r, s, m_mode == 4, 2'(m_code));
    endfunction

    task automatic step(input logic [3:0] p, input logic c);
        ph      = p;
        clr_err = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_flags16"}, flags_a(), model_flags());
        check({tag, "_flags3"}, flags_b(), model_flags());
        check({tag, "_icount16"}, 32'(icount_a), 32'(m_ic16));
        check({tag, "_icount3"}, 32'(icount_b), 32'(m_ic3));
    endtask

    task automatic do_reset();
        RSTN    = 1'b0;
        ph      = 4'b0000;
        clr_err = 1'b0;
        #20;
        RSTN = 1'b1;
        model_reset();
    endtask

    function automatic logic [3:0] legal_next(input int mode);
        logic [3:0] v;
        v = 4'b0000;
        v[(mode < 0 || mode > 3) ? 0 : (mode + 1) % 4] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [3:0] p;
        logic       c;
        int         r;

        RSTN    = 1'b0;
        ph      = 4'b0000;
        clr_err = 1'b0;
        model_reset();

        // table: power-on run, mid-instruction stop, every error kind and the clear rules
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 0});
        for (int k = 0; k < 3; k++) begin
            tbl.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, k});
            tbl.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, k});
            tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, k});
            tbl.push_back('{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd0, k + 1});
        end
        tbl.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 3});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 3});
        tbl.push_back('{4'b0011, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 3});
        tbl.push_back('{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 3});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 3});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0011, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 3});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 3});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0110, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 3});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 3});
        tbl.push_back('{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 3});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3});

        #50;
        check("reset_flags16", flags_a(), 32'd0);
        check("reset_flags3", flags_b(), 32'd0);
        check("reset_icount16", 32'(icount_a), 32'd0);
        check("reset_icount3", 32'(icount_b), 32'd0);
        #50;
        RSTN = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ph, tbl[i].clr);
            check($sformatf("tbl%0d_flags16", i), flags_a(),
                  pack_exp(tbl[i].run, tbl[i].str, tbl[i].err, tbl[i].code));
            check($sformatf("tbl%0d_flags3", i), flags_b(),
                  pack_exp(tbl[i].run, tbl[i].str, tbl[i].err, tbl[i].code));
            check($sformatf("tbl%0d_icount16", i), 32'(icount_a), 32'(tbl[i].ic));
        end

        // saturation: ten instructions, narrow counter parks at 7
        do_reset();
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                p = 4'b0001 << j;
                step(p, 1'b0);
                model_full(p, 1'b0);
            end
        end
        check("sat_icount16", 32'(icount_a), 32'd10);
        check("sat_icount3", 32'(icount_b), 32'd7);
        check("sat_wb", 32'(wb_b), 32'd1);

        // asynchronous reset mid-instruction, observed before the next clock edge
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        #3;
        RSTN = 1'b0;
        #1;
        check("async_flags16", flags_a(), 32'd0);
        check("async_flags3", flags_b(), 32'd0);
        check("async_icount16", 32'(icount_a), 32'd0);
        check("async_icount3", 32'(icount_b), 32'd0);
        ph = 4'b0000;
        #2;
        RSTN = 1'b1;
        model_reset();

        // random traffic, mostly legal with stops, skips, repeats, multi-bit values and clears
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (m_mode == 4) begin
                p = (r < 60) ? 4'b0000 : 4'($urandom_range(0, 15));
                c = ($urandom_range(0, 2) != 0);
            end else begin
                if (r < 80)      p = legal_next(m_mode);
                else if (r < 88) p = 4'b0000;
                else             p = 4'($urandom_range(0, 15));
                c = ($urandom_range(0, 5) == 0);
            end
            step(p, c);
            model_full(p, c);
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
